// File: rtl/alu_seq.sv
// alu_seq: registered ALU with an iterative unsigned multiply/divide unit behind valid/ready handshakes
module alu_seq #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [4:0]      i_op,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_res
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t          state, state_nxt;
  logic [XLEN-1:0] hi, lo, opnd, hi_nxt, lo_nxt, base_res;
  logic [XLEN:0]   sum, sh;
  logic [1:0]      mop;
  logic [SHW-1:0]  cnt, shamt;
  logic            acc, last, ge;
  // combinational base ALU; unknown codes yield zero
  always_comb begin
    shamt = i_b[SHW-1:0];
    base_res = '0;
    case (i_op[3:0])
      ALU_ADD:  base_res = i_a + i_b;
      ALU_SUB:  base_res = i_a - i_b;
      ALU_SLL:  base_res = i_a << shamt;
      ALU_SLT:  base_res = XLEN'($signed(i_a) < $signed(i_b));
      ALU_SLTU: base_res = XLEN'(i_a < i_b);
      ALU_XOR:  base_res = i_a ^ i_b;
      ALU_SRL:  base_res = i_a >> shamt;
      ALU_SRA:  base_res = $unsigned($signed(i_a) >>> shamt);
      ALU_OR:   base_res = i_a | i_b;
      ALU_AND:  base_res = i_a & i_b;
      default:  base_res = '0;
    endcase
  end
  // handshake outputs and next state; a transfer with a new accept behaves like IDLE
  always_comb begin
    o_ready = state == IDLE || (state == DONE && i_ready);
    o_valid = state == DONE;
    acc = i_valid && o_ready;
    last = cnt == SHW'(XLEN - 1);
    state_nxt = state;
    if (acc) state_nxt = i_op[4] ? BUSY : DONE;
    else if (state == DONE && i_ready) state_nxt = IDLE;
    else if (state == BUSY && last) state_nxt = DONE;
  end
  // one iteration: shift-add on {hi,lo} for multiply, restoring shift-subtract for divide
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    sh = {hi, lo[XLEN-1]};
    ge = sh >= {1'b0, opnd};
    hi_nxt = mop[1] ? (ge ? XLEN'(sh - {1'b0, opnd}) : sh[XLEN-1:0]) : sum[XLEN:1];
    lo_nxt = mop[1] ? {lo[XLEN-2:0], ge} : {sum[0], lo[XLEN-1:1]};
  end
  // state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  // datapath: base results registered on accept, M ops iterate XLEN times then register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_res <= '0;
      hi <= '0;
      lo <= '0;
      opnd <= '0;
      mop <= '0;
      cnt <= '0;
    end else if (acc) begin
      if (!i_op[4]) o_res <= base_res;
      else begin
        mop <= i_op[1:0];
        cnt <= '0;
        hi <= '0;
        lo <= i_op[1] ? i_a : i_b;
        opnd <= i_op[1] ? i_b : i_a;
      end
    end else if (state == BUSY) begin
      hi <= hi_nxt;
      lo <= lo_nxt;
      cnt <= cnt + 1'b1;
      if (last) o_res <= mop[0] ? hi_nxt : lo_nxt;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against a cycle-level behavioural model
module tb_alu_seq;
  localparam int XLEN = 32;
  logic            i_clk = 0, i_rst_n = 0, i_valid = 0, i_ready = 1;
  logic            o_ready, o_valid;
  logic [XLEN-1:0] i_a = 0, i_b = 0, o_res;
  logic [4:0]      i_op = 0;
  int checks = 0, errors = 0;

  alu_seq #(.XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_op(i_op), .o_valid(o_valid), .i_ready(i_ready), .o_res(o_res)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    if (op[4])
      case (op[1:0])
        2'd0: return p[31:0];
        2'd1: return p[63:32];
        2'd2: return b == 0 ? 32'hFFFF_FFFF : a / b;
        default: return b == 0 ? a : a % b;
      endcase
    case (op[3:0])
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a << b[4:0];
      4'd3: return {31'd0, $signed(a) < $signed(b)};
      4'd4: return {31'd0, a < b};
      4'd5: return a ^ b;
      4'd6: return a >> b[4:0];
      4'd7: return $unsigned($signed(a) >>> b[4:0]);
      4'd8: return a | b;
      4'd9: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  bit m_known = 0, m_valid = 0;
  int m_left = 0;
  logic [31:0] m_res = 0, m_pend = 0;

  always @(posedge i_clk) begin
    bit rdy;
    rdy = (m_left == 0 && !m_valid) || (m_valid && i_ready);
    if (!i_rst_n) begin
      m_known = 1; m_valid = 0; m_left = 0; m_res = 0;
    end else if (i_valid && rdy) begin
      if (i_op[4]) begin
        m_left = XLEN; m_valid = 0; m_pend = ref_op(i_op, i_a, i_b);
      end else begin
        m_valid = 1; m_res = ref_op(i_op, i_a, i_b);
      end
    end else if (m_valid && i_ready) m_valid = 0;
    else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_valid = 1; m_res = m_pend; end
    end
  end

  always @(negedge i_clk) begin
    if (m_known) begin
      chk("model_valid", {31'd0, o_valid}, {31'd0, m_valid});
      chk("model_ready", {31'd0, o_ready}, {31'd0, (m_left == 0 && !m_valid) || (m_valid && i_ready)});
      if (m_valid) chk("model_res", o_res, m_res);
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat_exp);
    int lat = 0, low = 0;
    i_valid = 1; i_op = op; i_a = a; i_b = b;
    @(posedge i_clk); #1;
    i_valid = 0; i_a = $urandom; i_b = $urandom; i_op = 5'($urandom);
    do begin
      @(negedge i_clk);
      lat++;
      if (!o_ready) low++;
    end while (!o_valid && lat < 100);
    chk("latency", 32'(lat), 32'(lat_exp));
    chk("ready_low_cycles", 32'(low), 32'(lat_exp - 1));
    chk("result", o_res, exp);
    @(posedge i_clk); #1;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1;
    @(negedge i_clk);
    chk("reset_valid", {31'd0, o_valid}, 32'd0);
    chk("reset_ready", {31'd0, o_ready}, 32'd1);
    chk("reset_res", o_res, 32'd0);
    @(posedge i_clk); #1;
    issue(5'd0, 32'd4, 32'd10, 32'd14, 1);
    issue(5'd1, 32'd4, 32'd10, 32'hFFFF_FFFA, 1);
    issue(5'd7, 32'hFFFF_FFFC, 32'd2, 32'hFFFF_FFFF, 1);
    issue(5'd2, 32'd4, 32'd42, 32'h0000_1000, 1);
    issue(5'd6, 32'h8000_0000, 32'd35, 32'h1000_0000, 1);
    issue(5'd13, 32'd7, 32'd9, 32'd0, 1);
    issue(5'b10000, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 33);
    issue(5'b10001, 32'hFFFF_FFFF, 32'd3, 32'd2, 33);
    issue(5'b11110, 32'd100, 32'd7, 32'd14, 33);
    issue(5'b10011, 32'd100, 32'd7, 32'd2, 33);
    issue(5'b10010, 32'd100, 32'd0, 32'hFFFF_FFFF, 33);
    issue(5'b10011, 32'd100, 32'd0, 32'd100, 33);
    i_valid = 1; i_op = 5'd3; i_a = 32'hFFFF_FFF6; i_b = 32'd4;
    @(posedge i_clk); #1;
    i_op = 5'd4;
    @(negedge i_clk);
    chk("b2b_slt", o_res, 32'd1);
    chk("b2b_ready", {31'd0, o_ready}, 32'd1);
    @(posedge i_clk); #1;
    i_valid = 0;
    @(negedge i_clk);
    chk("b2b_sltu", o_res, 32'd0);
    chk("b2b_sltu_valid", {31'd0, o_valid}, 32'd1);
    @(posedge i_clk); #1;
    i_ready = 0; i_valid = 1; i_op = 5'd5; i_a = 32'b0010; i_b = 32'b1001;
    @(posedge i_clk); #1;
    for (int k = 0; k < 5; k++) begin
      i_valid = k[0]; i_op = 5'd0; i_a = $urandom; i_b = $urandom;
      @(negedge i_clk);
      chk("bp_res", o_res, 32'b1011);
      chk("bp_valid", {31'd0, o_valid}, 32'd1);
      chk("bp_ready", {31'd0, o_ready}, 32'd0);
      @(posedge i_clk); #1;
    end
    i_valid = 0; i_ready = 1;
    @(posedge i_clk); #1;
    @(negedge i_clk);
    chk("bp_idle_valid", {31'd0, o_valid}, 32'd0);
    chk("bp_idle_ready", {31'd0, o_ready}, 32'd1);
    @(posedge i_clk); #1;
    i_valid = 1; i_op = 5'b10000; i_a = 32'd12345; i_b = 32'd678;
    @(posedge i_clk); #1;
    i_valid = 0;
    repeat (9) @(posedge i_clk);
    #1 i_rst_n = 0;
    @(posedge i_clk); #1 i_rst_n = 1;
    @(negedge i_clk);
    chk("rst_mid_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, o_ready}, 32'd1);
    @(posedge i_clk); #1;
    issue(5'd0, 32'd1, 32'd1, 32'd2, 1);
    for (int c = 0; c < 2000; c++) begin
      i_rst_n = ($urandom % 300) != 0;
      i_valid = ($urandom % 10) < 6;
      i_ready = ($urandom % 10) < 7;
      i_op = 5'($urandom);
      i_a = rnd_val();
      i_b = rnd_val();
      @(posedge i_clk); #1;
    end
    i_rst_n = 1; i_valid = 0; i_ready = 1;
    repeat (40) @(posedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
